// File: rtl/pp_row_accumulator_if.sv
// Handshake bundle between the row serializer, the row accumulator and the reduction datapath.
// The slave modport is the accumulator's view; the master modport is the producer/consumer side.
interface pp_row_accumulator_if #(
  parameter int W = 92
);
  logic              start;
  logic              row_valid;
  logic              row_ready;
  logic [2*W-1:0]    row_data;
  logic              prod_valid;
  logic              prod_ready;
  logic [2*W-1:0]    prod;
  logic              busy;
  logic              ovf;

  modport master (
    output start, row_valid, row_data, prod_ready,
    input  row_ready, prod_valid, prod, busy, ovf
  );

  modport slave (
    input  start, row_valid, row_data, prod_ready,
    output row_ready, prod_valid, prod, busy, ovf
  );
endinterface

// File: rtl/pp_row_accumulator.sv
// Sums ROWS shifted partial-product rows modulo 2^(2W) and hands the product downstream.
// Define PP_ACC_CARRY_SAVE_EN for a carry-save accumulator with one extra FINAL resolve cycle.
module pp_row_accumulator #(
  parameter int W     = 92,
  parameter int ROWS  = 92,
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  pp_row_accumulator_if.slave bus
);
  localparam int PW = 2 * W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS - 1);

`ifdef PP_ACC_CARRY_SAVE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2, FINAL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              xfer;

`ifdef PP_ACC_CARRY_SAVE_EN
  logic [PW-1:0]     sum_q, sum_d;
  logic [PW-1:0]     carry_q, carry_d;
  logic [PW-1:0]     carry_sh;
  logic [PW:0]       cpa;
`else
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW:0]       add;
`endif

  assign xfer = (state_q == ACC) && bus.row_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    prod_d  = prod_q;
`ifdef PP_ACC_CARRY_SAVE_EN
    sum_d    = sum_q;
    carry_d  = carry_q;
    carry_sh = {carry_q[PW-2:0], 1'b0};
    cpa      = '0;
`else
    acc_d = acc_q;
    add   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACC;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef PP_ACC_CARRY_SAVE_EN
          sum_d   = '0;
          carry_d = '0;
`else
          acc_d   = '0;
`endif
        end
      end
      ACC: begin
        if (xfer) begin
`ifdef PP_ACC_CARRY_SAVE_EN
          // 3:2 compression; the carry bit shifted out of the top is a wrap of 2^(2W)
          sum_d   = bus.row_data ^ sum_q ^ carry_sh;
          carry_d = (bus.row_data & sum_q) | (bus.row_data & carry_sh) | (sum_q & carry_sh);
          ovf_d   = ovf_q | carry_q[PW-1];
`else
          add   = {1'b0, acc_q} + {1'b0, bus.row_data};
          acc_d = add[PW-1:0];
          ovf_d = ovf_q | add[PW];
`endif
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef PP_ACC_CARRY_SAVE_EN
            state_d = FINAL;
`else
            state_d = DONE;
            prod_d  = add[PW-1:0];
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef PP_ACC_CARRY_SAVE_EN
      FINAL: begin
        cpa     = {1'b0, sum_q} + {1'b0, carry_sh};
        prod_d  = cpa[PW-1:0];
        ovf_d   = ovf_q | carry_q[PW-1] | cpa[PW];
        state_d = DONE;
      end
`endif
      DONE: begin
        if (bus.prod_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      prod_q  <= '0;
`ifdef PP_ACC_CARRY_SAVE_EN
      sum_q   <= '0;
      carry_q <= '0;
`else
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      prod_q  <= prod_d;
`ifdef PP_ACC_CARRY_SAVE_EN
      sum_q   <= sum_d;
      carry_q <= carry_d;
`else
      acc_q   <= acc_d;
`endif
    end
  end

  // prod comes from a register written only with finished sums, so partials never leak out
  assign bus.row_ready  = (state_q == ACC);
  assign bus.prod_valid = (state_q == DONE);
  assign bus.prod       = prod_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_pp_row_accumulator.sv
// Scoreboard bench for pp_row_accumulator: expected products are queued at start and checked on prod_valid.
module tb_pp_row_accumulator;
  localparam int W    = 92;
  localparam int ROWS = 92;
  localparam int PW   = 2 * W;
`ifdef PP_ACC_CARRY_SAVE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [PW-1:0] prod;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pp_row_accumulator_if #(.W(W)) bus ();
  pp_row_accumulator_if #(.W(W)) bus1 ();

  pp_row_accumulator #(.W(W), .ROWS(ROWS), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  pp_row_accumulator #(.W(W), .ROWS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  exp_t sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [PW-1:0] mk_row(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
    logic [PW-1:0] r;
    r = {{W{1'b0}}, a};
    return b[i] ? (r << i) : '0;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.ovf  = 1'b0;
    return e;
  endfunction

  task automatic start_product(input exp_t e, input bool_push);
  endtask

  task automatic do_start(input exp_t e, input bit push);
    if (push) sb.push_back(e);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.row_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL start_enter_acc: busy=%b row_ready=%b required 1/1", bus.busy, bus.row_ready);
    end
  endtask

  // Drives rows until nrows transfers happen; reports early prod_valid and cycles used.
  task automatic send_rows(input logic [W-1:0] a, input logic [W-1:0] b, input bit gap,
                           input bit all_ones, input int nrows, output int sent,
                           output bit early, output int cyc);
    bit   tog;
    logic rdy;
    tog = 1'b1; sent = 0; early = 1'b0; cyc = 0;
    while (sent < nrows && cyc < 1000) begin
      bus.row_valid = gap ? tog : 1'b1;
      bus.row_data  = all_ones ? {PW{1'b1}} : mk_row(a, b, sent);
      rdy = bus.row_ready;
      @(posedge clk); #1;
      cyc++;
      if (bus.row_valid && rdy) sent++;
      if (sent < nrows && bus.prod_valid) early = 1'b1;
      tog = ~tog;
    end
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
  endtask

  task automatic collect(input string nm, input int hold, input bit pulse_start);
    int   lat;
    exp_t e;
    bit   stable;
    lat = 1;
    while (!bus.prod_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== LAT) begin
      n_mis++;
      $display("FAIL %s_latency: got %0d cycles required %0d", nm, lat, LAT);
    end
    if (sb.size() == 0) begin
      n_mis++;
      $display("FAIL %s_scoreboard: queue empty, got prod %0h required an entry", nm, bus.prod);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus.prod !== e.prod) begin
      n_mis++;
      $display("FAIL %s_prod: got %0h required %0h", nm, bus.prod, e.prod);
    end
    n_cmp++;
    if (bus.ovf !== e.ovf) begin
      n_mis++;
      $display("FAIL %s_ovf: got %b required %b", nm, bus.ovf, e.ovf);
    end
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.start = pulse_start;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.prod_valid !== 1'b1 || bus.prod !== e.prod) stable = 1'b0;
    end
    if (hold > 0) begin
      n_cmp++;
      if (stable !== 1'b1) begin
        n_mis++;
        $display("FAIL %s_stall_stable: got %b required 1", nm, stable);
      end
    end
    bus.prod_ready = 1'b1;
    @(posedge clk); #1;
    bus.prod_ready = 1'b0;
    n_cmp++;
    if (bus.prod_valid !== 1'b0 || bus.busy !== 1'b0 || bus.prod !== e.prod) begin
      n_mis++;
      $display("FAIL %s_handshake_idle: valid=%b busy=%b prod=%0h required 0/0/%0h",
               nm, bus.prod_valid, bus.busy, bus.prod, e.prod);
    end
  endtask

  task automatic run_product(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit gap, input int hold, input bit pulse_start);
    int sent, cyc;
    bit early;
    do_start(model(a, b), 1'b1);
    send_rows(a, b, gap, 1'b0, ROWS, sent, early, cyc);
    n_cmp++;
    if (sent !== ROWS || early !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_transfers: got %0d (early=%b) required %0d (early=0)", nm, sent, early, ROWS);
    end
    if (gap) begin
      n_cmp++;
      if (cyc !== 2 * ROWS - 1) begin
        n_mis++;
        $display("FAIL %s_gap_cycles: got %0d required %0d", nm, cyc, 2 * ROWS - 1);
      end
    end
    collect(nm, hold, pulse_start);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.row_valid = 1'b0; bus.row_data = '0; bus.prod_ready = 1'b0;
    bus1.start = 1'b0; bus1.row_valid = 1'b0; bus1.row_data = '0; bus1.prod_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.row_ready !== 1'b0) begin n_mis++; $display("FAIL reset_row_ready: got %b required 0", bus.row_ready); end
    n_cmp++;
    if (bus.prod_valid !== 1'b0) begin n_mis++; $display("FAIL reset_prod_valid: got %b required 0", bus.prod_valid); end
    n_cmp++;
    if (bus.prod !== '0) begin n_mis++; $display("FAIL reset_prod: got %0h required 0", bus.prod); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_cmp++;
    if (bus.ovf !== 1'b0) begin n_mis++; $display("FAIL reset_ovf: got %b required 0", bus.ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.row_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL idle_no_start: busy=%b row_ready=%b required 0/0", bus.busy, bus.row_ready);
    end
  endtask

  task automatic test_unit();
    run_product("unit", 92'd1, 92'd1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_max();
    run_product("max", {W{1'b1}}, {W{1'b1}}, 1'b0, 0, 1'b0);
  endtask

  task automatic test_gap();
    run_product("gap", {W{1'b1}}, {W{1'b1}}, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_product("stall", 92'd7, 92'd9, 1'b0, 5, 1'b1);
  endtask

  task automatic test_reset_mid();
    int sent, cyc;
    bit early;
    exp_t dummy;
    dummy = model({W{1'b1}}, {W{1'b1}});
    do_start(dummy, 1'b0);
    send_rows({W{1'b1}}, {W{1'b1}}, 1'b0, 1'b0, 40, sent, early, cyc);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.row_ready !== 1'b0 || bus.prod !== '0 || bus.ovf !== 1'b0) begin
      n_mis++;
      $display("FAIL midreset_values: busy=%b ready=%b prod=%0h ovf=%b required 0/0/0/0",
               bus.busy, bus.row_ready, bus.prod, bus.ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_product("after_reset", 92'd3, 92'd5, 1'b0, 0, 1'b0);
  endtask

  task automatic test_all_ones();
    int   sent, cyc;
    bit   early;
    exp_t e;
    e.prod = {PW{1'b1}};
    e.prod = e.prod - PW'(91);
    e.ovf  = 1'b1;
    do_start(e, 1'b1);
    send_rows('0, '0, 1'b0, 1'b1, ROWS, sent, early, cyc);
    n_cmp++;
    if (sent !== ROWS) begin
      n_mis++;
      $display("FAIL allones_transfers: got %0d required %0d", sent, ROWS);
    end
    collect("allones", 0, 1'b0);
  endtask

  task automatic test_rows1();
    logic [PW-1:0] v;
    int lat;
    v = {PW{1'b0}};
    v[PW-1] = 1'b1;
    v[15:0] = 16'hbeef;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus1.row_valid = 1'b1;
    bus1.row_data  = v;
    @(posedge clk); #1;
    bus1.row_valid = 1'b0;
    bus1.row_data  = '0;
    lat = 1;
    while (!bus1.prod_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== LAT || bus1.prod !== v || bus1.ovf !== 1'b0) begin
      n_mis++;
      $display("FAIL rows1_single: lat=%0d prod=%0h ovf=%b required %0d/%0h/0", lat, bus1.prod, bus1.ovf, LAT, v);
    end
    bus1.prod_ready = 1'b1;
    @(posedge clk); #1;
    bus1.prod_ready = 1'b0;
    n_cmp++;
    if (bus1.busy !== 1'b0) begin n_mis++; $display("FAIL rows1_idle: busy got %b required 0", bus1.busy); end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_max();
    test_gap();
    test_stall();
    test_reset_mid();
    test_all_ones();
    test_rows1();
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
